// File: rtl/cart_bus_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cart_bus_pkg
// Shared types and constants for the Game Boy cartridge bus sequencer and
// every block that issues requests to it.
//   cart_bus_state_t : sequencer phase (IDLE, SETUP, ACCESS, HOLD)
//   cart_bus_req_t   : one bus request (we, addr, wdata)
//   CART_RAM_BASE/END: external-RAM window that asserts cart_cs_n
//   is_cart_ram()    : address-in-RAM-window test
// -----------------------------------------------------------------------------
package cart_bus_pkg;

   localparam logic [15:0] CART_RAM_BASE = 16'hA000;
   localparam logic [15:0] CART_RAM_END  = 16'hBFFF;

   // Phase counter width; every phase length must fit as (cycles - 1).
   localparam int TIMER_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD
   } cart_bus_state_t;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } cart_bus_req_t;

   function automatic logic is_cart_ram(input logic [15:0] addr);
      return (addr >= CART_RAM_BASE) && (addr <= CART_RAM_END);
   endfunction

endpackage

// File: rtl/cart_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// cart_bus_sequencer_if
// Request handshake plus cartridge pin bundle of the bus sequencer.
//   slave  : the sequencer (takes requests and cart_d_in, drives the pins)
//   master : the requester / cartridge side (drives requests and cart_d_in)
// Signals: req, req_we, req_addr, req_wdata, ready, rdata, rdata_valid, done,
//          cart_a, cart_cs_n, cart_rd_n, cart_wr_n, cart_d_out, cart_d_oe,
//          cart_d_in.
// -----------------------------------------------------------------------------
interface cart_bus_sequencer_if;

   logic        req;
   logic        req_we;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        ready;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic        done;
   logic [15:0] cart_a;
   logic        cart_cs_n;
   logic        cart_rd_n;
   logic        cart_wr_n;
   logic [7:0]  cart_d_out;
   logic        cart_d_oe;
   logic [7:0]  cart_d_in;

   modport slave (
      input  req, req_we, req_addr, req_wdata, cart_d_in,
      output ready, rdata, rdata_valid, done,
      output cart_a, cart_cs_n, cart_rd_n, cart_wr_n, cart_d_out, cart_d_oe
   );

   modport master (
      output req, req_we, req_addr, req_wdata, cart_d_in,
      input  ready, rdata, rdata_valid, done,
      input  cart_a, cart_cs_n, cart_rd_n, cart_wr_n, cart_d_out, cart_d_oe
   );

endinterface

// File: rtl/cart_bus_sequencer_timer.sv
// -----------------------------------------------------------------------------
// cart_bus_timer
// Loadable down-counter with a zero flag, shared by the SETUP, ACCESS and HOLD
// phases of the sequencer. Stops at zero.
//   clk_6_7    : system clock
//   reset      : asynchronous active-high reset (count -> 0)
//   load       : load load_value (has priority over dec)
//   load_value : phase length minus one
//   dec        : decrement when non-zero
//   zero       : count is zero
// -----------------------------------------------------------------------------
module cart_bus_timer
   import cart_bus_pkg::*;
(
   input  logic               clk_6_7,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   input  logic               dec,
   output logic               zero
);

   logic [TIMER_W-1:0] count_reg;

   always_ff @(posedge clk_6_7 or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - TIMER_W'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/cart_bus_sequencer.sv
// -----------------------------------------------------------------------------
// cart_bus_sequencer
// Runs one single-byte cartridge bus cycle per accepted request:
// address/chip-select/data set up at acceptance, strobe low after SETUP_CYCLES,
// strobe high (and read data captured) ACCESS_CYCLES later, then HOLD_CYCLES
// with address/cs/data still driven before returning to idle.
// Parameters: SETUP_CYCLES, ACCESS_CYCLES, HOLD_CYCLES (each 1..15)
// Ports:
//   clk_6_7 : system clock
//   reset   : asynchronous active-high reset
//   bus     : cart_bus_sequencer_if.slave (request handshake + cart pins)
// All outputs are registered.
// -----------------------------------------------------------------------------
module cart_bus_sequencer
   import cart_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES  = 1,
   parameter int unsigned ACCESS_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES   = 1
) (
   input  logic                 clk_6_7,
   input  logic                 reset,
   cart_bus_sequencer_if.slave  bus
);

   // Phase lengths must fit the 4-bit timer as (cycles - 1), and zero is meaningless.
   if ((SETUP_CYCLES < 1) || (SETUP_CYCLES > 15)) begin : g_bad_setup
      $error("cart_bus_sequencer: SETUP_CYCLES=%0d outside 1..15", SETUP_CYCLES);
   end
   if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15)) begin : g_bad_access
      $error("cart_bus_sequencer: ACCESS_CYCLES=%0d outside 1..15", ACCESS_CYCLES);
   end
   if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 15)) begin : g_bad_hold
      $error("cart_bus_sequencer: HOLD_CYCLES=%0d outside 1..15", HOLD_CYCLES);
   end

   localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(SETUP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] ACCESS_LOAD = TIMER_W'(ACCESS_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HOLD_LOAD   = TIMER_W'(HOLD_CYCLES - 1);

   cart_bus_state_t    state_reg, state_next;
   logic               we_reg, we_next;
   logic               ready_reg, ready_next;
   logic [7:0]         rdata_reg, rdata_next;
   logic               rdata_valid_reg, rdata_valid_next;
   logic               done_reg, done_next;
   logic [15:0]        cart_a_reg, cart_a_next;
   logic               cart_cs_n_reg, cart_cs_n_next;
   logic               cart_rd_n_reg, cart_rd_n_next;
   logic               cart_wr_n_reg, cart_wr_n_next;
   logic [7:0]         cart_d_out_reg, cart_d_out_next;
   logic               cart_d_oe_reg, cart_d_oe_next;

   logic               timer_load;
   logic               timer_dec;
   logic [TIMER_W-1:0] timer_value;
   logic               timer_zero;

   cart_bus_req_t      req_in;

   assign req_in = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};

   cart_bus_timer u_timer (
      .clk_6_7    (clk_6_7),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .dec        (timer_dec),
      .zero       (timer_zero)
   );

   always_ff @(posedge clk_6_7 or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         we_reg          <= 1'b0;
         ready_reg       <= 1'b1;
         rdata_reg       <= '0;
         rdata_valid_reg <= 1'b0;
         done_reg        <= 1'b0;
         cart_a_reg      <= '0;
         cart_cs_n_reg   <= 1'b1;
         cart_rd_n_reg   <= 1'b1;
         cart_wr_n_reg   <= 1'b1;
         cart_d_out_reg  <= '0;
         cart_d_oe_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         we_reg          <= we_next;
         ready_reg       <= ready_next;
         rdata_reg       <= rdata_next;
         rdata_valid_reg <= rdata_valid_next;
         done_reg        <= done_next;
         cart_a_reg      <= cart_a_next;
         cart_cs_n_reg   <= cart_cs_n_next;
         cart_rd_n_reg   <= cart_rd_n_next;
         cart_wr_n_reg   <= cart_wr_n_next;
         cart_d_out_reg  <= cart_d_out_next;
         cart_d_oe_reg   <= cart_d_oe_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      we_next          = we_reg;
      ready_next       = ready_reg;
      rdata_next       = rdata_reg;
      rdata_valid_next = 1'b0;
      done_next        = 1'b0;
      cart_a_next      = cart_a_reg;
      cart_cs_n_next   = cart_cs_n_reg;
      cart_rd_n_next   = cart_rd_n_reg;
      cart_wr_n_next   = cart_wr_n_reg;
      cart_d_out_next  = cart_d_out_reg;
      cart_d_oe_next   = cart_d_oe_reg;
      timer_load       = 1'b0;
      timer_dec        = 1'b0;
      timer_value      = '0;

      case (state_reg)
         IDLE: begin
            if (bus.req && ready_reg) begin
               we_next        = req_in.we;
               ready_next     = 1'b0;
               cart_a_next    = req_in.addr;
               cart_cs_n_next = ~is_cart_ram(req_in.addr);
               // Reads leave cart_d_out at its previous value; only oe matters.
               if (req_in.we) begin
                  cart_d_out_next = req_in.wdata;
                  cart_d_oe_next  = 1'b1;
               end
               timer_load  = 1'b1;
               timer_value = SETUP_LOAD;
               state_next  = SETUP;
            end
         end

         SETUP: begin
            if (timer_zero) begin
               // Exactly one strobe goes low, chosen by the latched direction.
               if (we_reg) begin
                  cart_wr_n_next = 1'b0;
               end else begin
                  cart_rd_n_next = 1'b0;
               end
               timer_load  = 1'b1;
               timer_value = ACCESS_LOAD;
               state_next  = ACCESS;
            end else begin
               timer_dec = 1'b1;
            end
         end

         ACCESS: begin
            if (timer_zero) begin
               cart_rd_n_next = 1'b1;
               cart_wr_n_next = 1'b1;
               // Capture on the same edge the strobe releases.
               if (!we_reg) begin
                  rdata_next       = bus.cart_d_in;
                  rdata_valid_next = 1'b1;
               end
               timer_load  = 1'b1;
               timer_value = HOLD_LOAD;
               state_next  = HOLD;
            end else begin
               timer_dec = 1'b1;
            end
         end

         HOLD: begin
            if (timer_zero) begin
               cart_cs_n_next = 1'b1;
               cart_d_oe_next = 1'b0;
               done_next      = 1'b1;
               ready_next     = 1'b1;
               state_next     = IDLE;
            end else begin
               timer_dec = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.ready       = ready_reg;
   assign bus.rdata       = rdata_reg;
   assign bus.rdata_valid = rdata_valid_reg;
   assign bus.done        = done_reg;
   assign bus.cart_a      = cart_a_reg;
   assign bus.cart_cs_n   = cart_cs_n_reg;
   assign bus.cart_rd_n   = cart_rd_n_reg;
   assign bus.cart_wr_n   = cart_wr_n_reg;
   assign bus.cart_d_out  = cart_d_out_reg;
   assign bus.cart_d_oe   = cart_d_oe_reg;

endmodule

// File: tb/tb_cart_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cart_bus_sequencer
// Two sequencer instances: dut_d with default timing (1/4/1) and dut_p with
// S=3, A=7, H=2. Each transaction is checked cycle by cycle against a
// waveform computed directly from the phase boundaries S, S+A, S+A+H.
// -----------------------------------------------------------------------------
module tb_cart_bus_sequencer;

   logic clk_6_7 = 1'b0;
   logic reset   = 1'b1;

   always #75 clk_6_7 = ~clk_6_7;

   cart_bus_sequencer_if bus_d ();
   cart_bus_sequencer_if bus_p ();

   cart_bus_sequencer #(
      .SETUP_CYCLES  (1),
      .ACCESS_CYCLES (4),
      .HOLD_CYCLES   (1)
   ) dut_d (
      .clk_6_7 (clk_6_7),
      .reset   (reset),
      .bus     (bus_d)
   );

   cart_bus_sequencer #(
      .SETUP_CYCLES  (3),
      .ACCESS_CYCLES (7),
      .HOLD_CYCLES   (2)
   ) dut_p (
      .clk_6_7 (clk_6_7),
      .reset   (reset),
      .bus     (bus_p)
   );

   typedef struct packed {
      logic        ready;
      logic [7:0]  rdata;
      logic        rdata_valid;
      logic        done;
      logic [15:0] cart_a;
      logic        cs_n;
      logic        rd_n;
      logic        wr_n;
      logic [7:0]  d_out;
      logic        d_oe;
   } obs_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  din;
      logic        exp_cs_n;
      logic [7:0]  exp_rdata;
   } vec_t;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int p_s [2] = '{1, 3};
   int p_a [2] = '{4, 7};
   int p_h [2] = '{1, 2};

   logic [7:0] m_rdata [2] = '{8'h00, 8'h00};
   logic [7:0] m_dout  [2] = '{8'h00, 8'h00};

   always @(posedge clk_6_7) cyc <= cyc + 1;

   initial begin
      #(6_000_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic obs_t sample(input int sel);
      obs_t o;
      if (sel == 0) begin
         o = '{bus_d.ready, bus_d.rdata, bus_d.rdata_valid, bus_d.done, bus_d.cart_a,
               bus_d.cart_cs_n, bus_d.cart_rd_n, bus_d.cart_wr_n, bus_d.cart_d_out, bus_d.cart_d_oe};
      end else begin
         o = '{bus_p.ready, bus_p.rdata, bus_p.rdata_valid, bus_p.done, bus_p.cart_a,
               bus_p.cart_cs_n, bus_p.cart_rd_n, bus_p.cart_wr_n, bus_p.cart_d_out, bus_p.cart_d_oe};
      end
      return o;
   endfunction

   function automatic obs_t reset_obs();
      return '{1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
   endfunction

   // Expected pins k cycles after the acceptance edge, from the phase rules.
   function automatic obs_t expect_k(input int k, input int s, input int a, input int h,
                                     input logic we, input logic [15:0] addr,
                                     input logic [7:0] wdata, input logic [7:0] din,
                                     input logic [7:0] prev_rdata, input logic [7:0] prev_dout);
      obs_t e;
      int   t;
      logic ram;
      t             = s + a + h;
      ram           = (addr >= 16'hA000) && (addr <= 16'hBFFF);
      e.ready       = (k >= t);
      e.done        = (k == t);
      e.rdata_valid = !we && (k == s + a);
      e.rdata       = (!we && (k >= s + a)) ? din : prev_rdata;
      e.cart_a      = addr;
      e.cs_n        = (k >= t) ? 1'b1 : !ram;
      e.rd_n        = !(!we && (k >= s) && (k < s + a));
      e.wr_n        = !(we && (k >= s) && (k < s + a));
      e.d_out       = we ? wdata : prev_dout;
      e.d_oe        = we && (k < t);
      return e;
   endfunction

   task automatic check_obs(input string name, input int k, input obs_t act, input obs_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s k=%0d got rdy=%b rd=%h rv=%b dn=%b a=%h cs=%b rdn=%b wrn=%b do=%h oe=%b need rdy=%b rd=%h rv=%b dn=%b a=%h cs=%b rdn=%b wrn=%b do=%h oe=%b",
                  name, k, act.ready, act.rdata, act.rdata_valid, act.done, act.cart_a, act.cs_n,
                  act.rd_n, act.wr_n, act.d_out, act.d_oe, exp.ready, exp.rdata, exp.rdata_valid,
                  exp.done, exp.cart_a, exp.cs_n, exp.rd_n, exp.wr_n, exp.d_out, exp.d_oe);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0h need %0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int sel, input logic req, input logic we,
                            input logic [15:0] addr, input logic [7:0] wdata);
      if (sel == 0) begin
         bus_d.req = req; bus_d.req_we = we; bus_d.req_addr = addr; bus_d.req_wdata = wdata;
      end else begin
         bus_p.req = req; bus_p.req_we = we; bus_p.req_addr = addr; bus_p.req_wdata = wdata;
      end
   endtask

   task automatic drive_din(input int sel, input logic [7:0] d);
      if (sel == 0) bus_d.cart_d_in = d;
      else          bus_p.cart_d_in = d;
   endtask

   // Called at a sample point (#1 after a posedge). Returns at the sample
   // point of the edge where done pulses, with req dropped.
   task automatic do_txn(input int sel, input logic we, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic [7:0] din, input bit noise,
                         output logic cs_first, output int acc_cyc);
      int   s, a, h, t, w;
      obs_t o, e;
      s = p_s[sel]; a = p_a[sel]; h = p_h[sel]; t = s + a + h;
      cs_first = 1'b1;
      w = 0;
      o = sample(sel);
      while (!o.ready && (w < 50)) begin
         @(posedge clk_6_7); #1;
         o = sample(sel);
         w++;
      end
      check_val("ready_before_req", 32'(o.ready), 32'd1);
      drive_req(sel, 1'b1, we, addr, wdata);
      drive_din(sel, 8'($urandom));
      @(posedge clk_6_7); #1;
      acc_cyc = cyc;
      for (int k = 0; k <= t; k++) begin
         if (k > 0) begin
            @(posedge clk_6_7); #1;
         end
         o = sample(sel);
         e = expect_k(k, s, a, h, we, addr, wdata, din, m_rdata[sel], m_dout[sel]);
         check_obs(we ? "txn_write" : "txn_read", k, o, e);
         if (k == 0) cs_first = o.cs_n;
         // While busy, extra requests with junk fields must be ignored.
         if (noise && (k < t))
            drive_req(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom), 8'($urandom));
         else
            drive_req(sel, 1'b0, 1'b0, 16'h0000, 8'h00);
         drive_din(sel, (k == s + a - 1) ? din : 8'($urandom));
      end
      if (we) m_dout[sel] = wdata;
      else    m_rdata[sel] = din;
      $display("[TB] txn dut=%0d %s addr=%h wdata=%h din=%h acc_cyc=%0d rdata=%h",
               sel, we ? "WR" : "RD", addr, wdata, din, acc_cyc, sample(sel).rdata);
   endtask

   vec_t vecs [7];

   initial begin
      obs_t o;
      logic cs_f;
      int   acc, prev_acc, pulses, g;
      logic r_we;
      logic [15:0] r_addr;

      vecs[0] = '{1'b0, 16'h0134, 8'h00, 8'h47, 1'b1, 8'h47};
      vecs[1] = '{1'b1, 16'h4000, 8'h10, 8'hEE, 1'b1, 8'h47};
      vecs[2] = '{1'b0, 16'hA123, 8'h00, 8'hC3, 1'b0, 8'hC3};
      vecs[3] = '{1'b0, 16'h9FFF, 8'h00, 8'h01, 1'b1, 8'h01};
      vecs[4] = '{1'b1, 16'hBFFF, 8'h5E, 8'h77, 1'b0, 8'h01};
      vecs[5] = '{1'b0, 16'hC000, 8'h00, 8'hFF, 1'b1, 8'hFF};
      vecs[6] = '{1'b0, 16'hA000, 8'h00, 8'h00, 1'b0, 8'h00};

      drive_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      drive_req(1, 1'b0, 1'b0, 16'h0000, 8'h00);
      drive_din(0, 8'h00);
      drive_din(1, 8'h00);

      // Reset state
      repeat (2) @(posedge clk_6_7);
      #1;
      check_obs("reset_dut_d", 0, sample(0), reset_obs());
      check_obs("reset_dut_p", 0, sample(1), reset_obs());
      @(negedge clk_6_7);
      reset = 1'b0;
      @(posedge clk_6_7); #1;
      check_obs("post_reset_idle", 0, sample(0), reset_obs());

      // Directed vectors, back-to-back (each request raised while done pulses)
      prev_acc = 0;
      for (int i = 0; i < 7; i++) begin
         do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].din, 1'b0, cs_f, acc);
         check_val("vec_cs_n", 32'(cs_f), 32'(vecs[i].exp_cs_n));
         check_val("vec_rdata", 32'(sample(0).rdata), 32'(vecs[i].exp_rdata));
         if (i > 0) check_val("vec_accept_spacing", 32'(acc - prev_acc), 32'd7);
         prev_acc = acc;
      end

      // req held continuously for 13 reads
      drive_din(0, 8'h5A);
      drive_req(0, 1'b1, 1'b0, 16'h0150, 8'h00);
      pulses = 0;
      for (int c = 0; c <= 90; c++) begin
         @(posedge clk_6_7); #1;
         o = sample(0);
         check_val("stream_ready", 32'(o.ready), 32'((c % 7) == 6));
         check_val("stream_rvalid", 32'(o.rdata_valid), 32'((c % 7) == 5));
         if (o.rdata_valid) pulses++;
         if (c == 90) drive_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      end
      check_val("stream_pulses", 32'(pulses), 32'd13);
      check_val("stream_rdata", 32'(o.rdata), 32'h5A);
      m_rdata[0] = 8'h5A;
      @(posedge clk_6_7); #1;
      check_val("stream_no_extra_accept", 32'(sample(0).ready), 32'd1);

      // Randomized transactions on default timing, with idle gaps and noise
      for (int i = 0; i < 40; i++) begin
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(posedge clk_6_7); #1;
            drive_din(0, 8'($urandom));
         end
         r_we = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       r_addr = 16'hA000;
            1:       r_addr = 16'hBFFF;
            2:       r_addr = 16'h9FFF;
            3:       r_addr = 16'hC000;
            default: r_addr = 16'($urandom);
         endcase
         do_txn(0, r_we, r_addr, 8'($urandom), 8'($urandom), 1'b1, cs_f, acc);
      end

      // Asynchronous reset in the middle of ACCESS (write to RAM window)
      drive_req(0, 1'b1, 1'b1, 16'hA010, 8'h99);
      @(posedge clk_6_7); #1;
      drive_req(0, 1'b0, 1'b0, 16'h0000, 8'h00);
      @(posedge clk_6_7); #1;
      o = sample(0);
      check_val("abort_in_access_wr_n", 32'(o.wr_n), 32'd0);
      check_val("abort_in_access_oe", 32'(o.d_oe), 32'd1);
      #20;
      reset = 1'b1;
      #1;
      check_obs("async_reset_midcycle", 0, sample(0), reset_obs());
      m_rdata[0] = 8'h00; m_dout[0] = 8'h00;
      m_rdata[1] = 8'h00; m_dout[1] = 8'h00;
      @(negedge clk_6_7);
      reset = 1'b0;
      @(posedge clk_6_7); #1;
      for (int c = 0; c < 8; c++) begin
         o = sample(0);
         check_val("abort_no_pulse", 32'({o.done, o.rdata_valid, o.ready}), 32'b001);
         @(posedge clk_6_7); #1;
      end
      do_txn(0, 1'b0, 16'hA123, 8'h00, 8'h3C, 1'b0, cs_f, acc);
      check_val("after_abort_rdata", 32'(sample(0).rdata), 32'h3C);

      // Non-default timing S=3 A=7 H=2
      do_txn(1, 1'b0, 16'h0134, 8'h00, 8'h11, 1'b0, cs_f, prev_acc);
      do_txn(1, 1'b0, 16'hA001, 8'h00, 8'h22, 1'b0, cs_f, acc);
      check_val("param_accept_spacing", 32'(acc - prev_acc), 32'd13);
      check_val("param_cs_ram", 32'(cs_f), 32'd0);
      for (int i = 0; i < 12; i++) begin
         g = $urandom_range(0, 2);
         repeat (g) begin
            @(posedge clk_6_7); #1;
            drive_din(1, 8'($urandom));
         end
         do_txn(1, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom),
                1'b1, cs_f, acc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cart_bus_sequencer.md
# cart_bus_sequencer

Sequences single-byte Game Boy cartridge bus cycles (read or write) from a valid/ready request interface, generating address, chip-select, RD/WR strobes and data-bus direction with parameterised setup/access/hold timing. Sits between the cartridge-side consumers (header verifier, MBC/camera register access, ROM/RAM dump logic) and the physical cartridge pins. It registers read data and pulses a valid strobe.

## Interface
- SETUP_CYCLES, 1, cycles address is stable before strobe assertion (legal 1..15)
- ACCESS_CYCLES, 4, cycles RD_n/WR_n held low (legal 1..15)
- HOLD_CYCLES, 1, cycles address/data held after strobe release (legal 1..15)
- clk_6_7  in  1  system clock, ~6.7 MHz
- reset  in  1  asynchronous, active-high reset
- req  in  1  request valid; must stay high with fields stable until accepted
- req_we  in  1  1 = write cycle, 0 = read cycle
- req_addr  in  16  cartridge address
- req_wdata  in  8  write data
- ready  out  1  block idle; request accepted on edge where req && ready
- rdata  out  8  captured read data; holds last value until the next read completes
- rdata_valid  out  1  one-cycle pulse, rdata updated (reads only)
- done  out  1  one-cycle pulse on return to IDLE (reads and writes)
- cart_a  out  16  cartridge address pins
- cart_cs_n  out  1  external-RAM chip select, active low
- cart_rd_n  out  1  read strobe, active low
- cart_wr_n  out  1  write strobe, active low
- cart_d_out  out  8  data driven to cartridge
- cart_d_oe  out  1  1 = drive cart_d_out onto the bus
- cart_d_in  in  8  data from cartridge; may change at any time, sampled only at capture edge

## Operation
- Reset values: ready=1, rdata=0, rdata_valid=0, done=0, cart_a=0, cart_cs_n=1, cart_rd_n=1, cart_wr_n=1, cart_d_out=0, cart_d_oe=0, state=IDLE.
- IDLE: ready=1. On req && ready, latch we/addr/wdata, drive cart_a=addr, cart_cs_n=0 iff addr in 0xA000..0xBFFF, and, for writes, cart_d_out=wdata, cart_d_oe=1. Load counter=SETUP_CYCLES-1. Go SETUP.
- SETUP: all strobes high. When counter==0, set cart_rd_n=0 (read) or cart_wr_n=0 (write), load counter=ACCESS_CYCLES-1, and go ACCESS. Otherwise decrement.
- ACCESS: when counter==0, release strobe to 1. For reads, rdata<=cart_d_in and rdata_valid<=1. Load counter=HOLD_CYCLES-1 and go HOLD. Otherwise decrement.
- HOLD: cart_a, cart_cs_n and cart_d_oe unchanged. When counter==0, set cart_cs_n=1, cart_d_oe=0, done<=1, ready<=1, and go IDLE. cart_a keeps its last value.
- req while ready=0 is ignored (not queued). Requester must keep holding it.
- cart_rd_n and cart_wr_n are never low simultaneously. cart_d_oe is never 1 during a read.
- Reset mid-cycle: immediate (asynchronous) return to reset values. No rdata_valid or done pulse for the aborted cycle.

## Timing
- Edge 0 = acceptance edge.
- Strobe falls at edge S (S=SETUP_CYCLES) and rises at edge S+A (A=ACCESS_CYCLES).
- Read data is sampled at edge S+A. rdata_valid is high for the cycle following edge S+A. Read latency is S+A cycles (defaults: 5). This fits within the 8-cycle wait window of the cartridge header verifier.
- done and ready are high after edge S+A+H (H=HOLD_CYCLES).
- Earliest next acceptance is at edge S+A+H+1, so throughput is one access per S+A+H+1 cycles (defaults: 7).
- A request asserted in the same cycle that done pulses is accepted at the following edge.
- Counter is 4 bits wide. Parameter value 0 is illegal and must be rejected by an elaboration-time assertion.

## Structure
- Package cart_bus_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD)
  - CART_RAM_BASE=16'hA000, CART_RAM_END=16'hBFFF
  - cart_bus_req_t struct (we, addr, wdata), shared with all requesters
- Sub-module cart_bus_timer: 4-bit loadable down-counter with a zero flag, reused for all three phases.

## Test plan
- Read from 0x0134 with defaults, cart_d_in=0x47 -> cart_a=0x0134, cart_cs_n=1, rd_n low edges 1..5, rdata=0x47, rdata_valid high exactly 1 cycle after edge 5, done after edge 6.
- Write 0x10 to 0x4000 -> wr_n low for 4 cycles, cart_d_oe=1 with d_out=0x10 from edge 0 through HOLD, rd_n stays 1, no rdata_valid, done after edge 6.
- Read at 0xA123 -> cart_cs_n=0 from edge 0 to edge 6. Read at 0x9FFF -> cart_cs_n=1 throughout.
- req held continuously for 13 reads -> accepted every 7 cycles, 13 rdata_valid pulses, ready=0 between acceptances.
- reset asserted during ACCESS -> rd_n/wr_n/cs_n=1 and d_oe=0 asynchronously, ready=1, no done or rdata_valid pulse. The next request completes normally.
- Parameters S=3, A=7, H=2 -> strobe low edges 3..10, rdata_valid after edge 10, next acceptance at edge 13.
